// File: rtl/pong_match_ctrl.sv
// Match-level sequencer for pong: serve, rally, point pause, game over.
// Drives datapath enables, serve direction, both scores and the winner.
//
// Ports:
//   clk         pixel-domain clock, shared with the ball/paddle datapath
//   reset       asynchronous, active-low
//   frame_tick  one-clk pulse per frame (datapath animate strobe)
//   launch      launch button level (synchronised, debounced)
//   left_hit    ball at left wall, level, held until ball_reset
//   right_hit   ball at right wall, level, held until ball_reset
//   state       IDLE=0 SERVE=1 PLAY=2 POINT=3 GAMEOVER=4
//   ball_reset  hold ball and paddles at serve positions
//   play_en     ball/paddle motion enabled
//   serve_dir   0 = serve rightward, 1 = serve leftward
//   score_p1    left player score
//   score_p2    right player score
//   game_over   match finished
//   winner      00 none, 01 p1, 10 p2

module pong_match_ctrl #(
    parameter int WIN_SCORE    = 11,
    parameter int SERVE_FRAMES = 180,
    parameter int POINT_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       launch,
    input  logic       left_hit,
    input  logic       right_hit,
    output logic [2:0] state,
    output logic       ball_reset,
    output logic       play_en,
    output logic       serve_dir,
    output logic [4:0] score_p1,
    output logic [4:0] score_p2,
    output logic       game_over,
    output logic [1:0] winner
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SERVE    = 3'd1,
        S_PLAY     = 3'd2,
        S_POINT    = 3'd3,
        S_GAMEOVER = 3'd4
    } state_e;

    localparam logic [4:0] WIN        = 5'(WIN_SCORE);
    localparam bit         AUTO_SERVE = (SERVE_FRAMES != 0);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);

    state_e     st_q;
    logic       launch_q;
    logic [7:0] frame_cnt;

    logic launch_rise;
    logic serve_due;
    logic point_due;
    logic p1_won;
    logic p2_won;

    assign launch_rise = launch & ~launch_q;
    assign serve_due   = AUTO_SERVE && frame_tick
                         && (frame_cnt == SERVE_LAST);
    assign point_due   = frame_tick && (frame_cnt == POINT_LAST);
    assign p1_won      = (score_p1 == WIN);
    assign p2_won      = (score_p2 == WIN);

    // Enables decode straight from the state register so an
    // asynchronous reset drops play_en without waiting for a clock.
    assign state      = st_q;
    assign play_en    = (st_q == S_PLAY);
    assign ball_reset = (st_q != S_PLAY);
    assign game_over  = (st_q == S_GAMEOVER);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q      <= S_IDLE;
            // Treat the button as already pressed so a press held
            // through reset does not start a match.
            launch_q  <= 1'b1;
            frame_cnt <= 8'd0;
            score_p1  <= 5'd0;
            score_p2  <= 5'd0;
            serve_dir <= 1'b0;
            winner    <= 2'b00;
        end else begin
            launch_q <= launch;

            if (frame_tick)
                frame_cnt <= frame_cnt + 8'd1;

            case (st_q)
                S_IDLE, S_GAMEOVER: begin
                    if (launch_rise) begin
                        st_q      <= S_SERVE;
                        frame_cnt <= 8'd0;
                        score_p1  <= 5'd0;
                        score_p2  <= 5'd0;
                        serve_dir <= 1'b0;
                        winner    <= 2'b00;
                    end
                end

                S_SERVE: begin
                    // Button and auto-serve landing together is
                    // still a single move to PLAY.
                    if (launch_rise || serve_due)
                        st_q <= S_PLAY;
                end

                S_PLAY: begin
                    if (left_hit && right_hit) begin
                        // Simultaneous walls: replay the point.
                        st_q      <= S_POINT;
                        frame_cnt <= 8'd0;
                    end else if (right_hit) begin
                        if (score_p1 != WIN)
                            score_p1 <= score_p1 + 5'd1;
                        serve_dir <= 1'b0;
                        st_q      <= S_POINT;
                        frame_cnt <= 8'd0;
                    end else if (left_hit) begin
                        if (score_p2 != WIN)
                            score_p2 <= score_p2 + 5'd1;
                        serve_dir <= 1'b1;
                        st_q      <= S_POINT;
                        frame_cnt <= 8'd0;
                    end
                end

                S_POINT: begin
                    if (point_due) begin
                        if (p1_won || p2_won) begin
                            st_q   <= S_GAMEOVER;
                            winner <= p1_won ? 2'b01 : 2'b10;
                        end else begin
                            st_q      <= S_SERVE;
                            frame_cnt <= 8'd0;
                        end
                    end
                end

                default: st_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl with a small expectation queue.
// A second instance covers the auto-serve-disabled configuration.

module tb_pong_match_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic frame_tick;
    logic launch;
    logic launch2;
    logic left_hit;
    logic right_hit;

    logic [2:0] state;
    logic       ball_reset;
    logic       play_en;
    logic       serve_dir;
    logic [4:0] score_p1;
    logic [4:0] score_p2;
    logic       game_over;
    logic [1:0] winner;

    logic [2:0] b_state;
    logic       b_ball_reset;
    logic       b_play_en;
    logic       b_serve_dir;
    logic [4:0] b_score_p1;
    logic [4:0] b_score_p2;
    logic       b_game_over;
    logic [1:0] b_winner;

    pong_match_ctrl #(
        .WIN_SCORE   (3),
        .SERVE_FRAMES(180),
        .POINT_FRAMES(60)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .launch    (launch),
        .left_hit  (left_hit),
        .right_hit (right_hit),
        .state     (state),
        .ball_reset(ball_reset),
        .play_en   (play_en),
        .serve_dir (serve_dir),
        .score_p1  (score_p1),
        .score_p2  (score_p2),
        .game_over (game_over),
        .winner    (winner)
    );

    pong_match_ctrl #(
        .WIN_SCORE   (11),
        .SERVE_FRAMES(0),
        .POINT_FRAMES(60)
    ) dut_b (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .launch    (launch2),
        .left_hit  (1'b0),
        .right_hit (1'b0),
        .state     (b_state),
        .ball_reset(b_ball_reset),
        .play_en   (b_play_en),
        .serve_dir (b_serve_dir),
        .score_p1  (b_score_p1),
        .score_p2  (b_score_p2),
        .game_over (b_game_over),
        .winner    (b_winner)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        string tag;
        int    st;
        int    p1;
        int    p2;
        int    dir;
        int    win;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int st,
                            input int p1, input int p2,
                            input int dir, input int win);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.p1  = p1;
        e.p2  = p2;
        e.dir = dir;
        e.win = win;
        sb.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".state"}, 32'(state), 32'(e.st));
            chk({e.tag, ".p1"}, 32'(score_p1), 32'(e.p1));
            chk({e.tag, ".p2"}, 32'(score_p2), 32'(e.p2));
            chk({e.tag, ".dir"}, 32'(serve_dir), 32'(e.dir));
            chk({e.tag, ".win"}, 32'(winner), 32'(e.win));
            chk({e.tag, ".play_en"}, 32'(play_en),
                32'(e.st == 2));
            chk({e.tag, ".ball_rst"}, 32'(ball_reset),
                32'(e.st != 2));
            chk({e.tag, ".go"}, 32'(game_over), 32'(e.st == 4));
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic press();
        launch = 1'b1;
        cyc(1);
        launch = 1'b0;
        cyc(1);
    endtask

    task automatic expect_now(input string tag, input int st,
                              input int p1, input int p2,
                              input int dir, input int win);
        push_exp(tag, st, p1, p2, dir, win);
        sb_check();
    endtask

    initial begin
        reset      = 1'b0;
        launch     = 1'b1;
        launch2    = 1'b0;
        frame_tick = 1'b0;
        left_hit   = 1'b0;
        right_hit  = 1'b0;
        #12;
        expect_now("reset", 0, 0, 0, 0, 0);

        @(negedge clk);
        reset = 1'b1;
        cyc(3);
        expect_now("held", 0, 0, 0, 0, 0);
        launch = 1'b0;
        cyc(2);
        expect_now("released", 0, 0, 0, 0, 0);
        launch = 1'b1;
        cyc(1);
        expect_now("start", 1, 0, 0, 0, 0);
        launch = 1'b0;
        cyc(1);

        launch2 = 1'b1;
        cyc(1);
        launch2 = 1'b0;
        chk("b_start", 32'(b_state), 32'd1);

        launch = 1'b1;
        cyc(1);
        launch = 1'b0;
        expect_now("serve_btn", 2, 0, 0, 0, 0);

        right_hit = 1'b1;
        cyc(1);
        expect_now("rhit", 3, 1, 0, 0, 0);
        cyc(9);
        expect_now("rhold", 3, 1, 0, 0, 0);
        right_hit = 1'b0;

        tick_n(59);
        expect_now("pt59", 3, 1, 0, 0, 0);
        tick_n(1);
        expect_now("pt60", 1, 1, 0, 0, 0);

        tick_n(179);
        expect_now("sv179", 1, 1, 0, 0, 0);
        tick_n(1);
        expect_now("sv180", 2, 1, 0, 0, 0);

        left_hit = 1'b1;
        cyc(1);
        left_hit = 1'b0;
        expect_now("lhit1", 3, 1, 1, 1, 0);
        tick_n(60);
        expect_now("pt_lhit1", 1, 1, 1, 1, 0);
        press();
        expect_now("play_let", 2, 1, 1, 1, 0);

        left_hit  = 1'b1;
        right_hit = 1'b1;
        cyc(1);
        left_hit  = 1'b0;
        right_hit = 1'b0;
        expect_now("let", 3, 1, 1, 1, 0);
        tick_n(60);
        press();

        left_hit = 1'b1;
        cyc(1);
        left_hit = 1'b0;
        expect_now("lhit2", 3, 1, 2, 1, 0);
        tick_n(60);
        press();

        left_hit = 1'b1;
        cyc(1);
        expect_now("lhit3", 3, 1, 3, 1, 0);
        tick_n(59);
        expect_now("win_pause", 3, 1, 3, 1, 0);
        tick_n(1);
        left_hit = 1'b0;
        expect_now("gameover", 4, 1, 3, 1, 2);
        cyc(3);
        expect_now("go_hold", 4, 1, 3, 1, 2);

        chk("b_noauto", 32'(b_state), 32'd1);

        press();
        expect_now("restart", 1, 0, 0, 0, 0);
        press();
        right_hit = 1'b1;
        cyc(1);
        right_hit = 1'b0;
        expect_now("rhit_m2", 3, 1, 0, 0, 0);
        tick_n(60);
        press();
        expect_now("play_m2", 2, 1, 0, 0, 0);

        #2;
        reset = 1'b0;
        #2;
        expect_now("async_rst", 0, 0, 0, 0, 0);
        chk("b_async_rst", 32'(b_state), 32'd0);
        cyc(2);
        reset = 1'b1;
        cyc(2);
        expect_now("post_rst", 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
